// File: rtl/issue_scoreboard_if.sv
// Decode/writeback/resolve handshake bundle between the core pipeline and issue_scoreboard.
// The master side is the pipeline; the slave side is the scoreboard.
interface issue_scoreboard_if #(
  parameter int unsigned REGNOBITS = 5,
  parameter int unsigned NUMREGS   = 32
);
  logic                 dec_valid;
  logic [REGNOBITS-1:0] dec_src1;
  logic [REGNOBITS-1:0] dec_src2;
  logic                 dec_uses_src2;
  logic [REGNOBITS-1:0] dec_dst;
  logic                 dec_wb;
  logic                 dec_ctrl;
  logic                 wb_valid;
  logic [REGNOBITS-1:0] wb_reg;
  logic                 resolve;
  logic                 redirect;
  logic                 issue;
  logic                 stall;
  logic                 flush;
  logic [NUMREGS-1:0]   busy;
  logic [1:0]           state;
  logic                 err;

  modport master (
    output dec_valid, dec_src1, dec_src2, dec_uses_src2, dec_dst, dec_wb, dec_ctrl,
    output wb_valid, wb_reg, resolve, redirect,
    input  issue, stall, flush, busy, state, err
  );

  modport slave (
    input  dec_valid, dec_src1, dec_src2, dec_uses_src2, dec_dst, dec_wb, dec_ctrl,
    input  wb_valid, wb_reg, resolve, redirect,
    output issue, stall, flush, busy, state, err
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue/hazard controller: per-register busy bits, control-transfer sequencer, writeback counter.
// Optional macro SCOREBOARD_R0_ZERO_EN: register 0 is never tracked and never causes a hazard.
module issue_scoreboard #(
  parameter int unsigned REGNOBITS   = 5,
  parameter int unsigned NUMREGS     = 32,
  parameter int unsigned MAXINFLIGHT = 2,
  parameter int unsigned FLUSHCYCLES = 1
) (
  input logic              clk,
  input logic              reset,
  issue_scoreboard_if.slave sb
);

  localparam int unsigned CntW = $clog2(MAXINFLIGHT + 1);

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StCtrlWait = 2'd1,
    StFlush    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUMREGS-1:0] busy_q, busy_d;
  logic [CntW-1:0]    inflight_q, inflight_d;
  logic [1:0]         flush_cnt_q, flush_cnt_d;
  logic               err_q, err_d;

  logic src1_busy, src2_busy, trk_dst, wb_trk;
  logic full, hz, issue, inc, dec, wb_err;

`ifdef SCOREBOARD_R0_ZERO_EN
  assign src1_busy = (sb.dec_src1 != '0) & busy_q[sb.dec_src1];
  assign src2_busy = (sb.dec_src2 != '0) & busy_q[sb.dec_src2];
  assign trk_dst   = sb.dec_wb & (sb.dec_dst != '0);
  assign wb_trk    = sb.wb_valid & (sb.wb_reg != '0);
`else
  assign src1_busy = busy_q[sb.dec_src1];
  assign src2_busy = busy_q[sb.dec_src2];
  assign trk_dst   = sb.dec_wb;
  assign wb_trk    = sb.wb_valid;
`endif

  // Hazard sees registered busy only: a register written back this cycle still stalls.
  assign full = (inflight_q == CntW'(MAXINFLIGHT));
  assign hz   = src1_busy | (sb.dec_uses_src2 & src2_busy) |
                (trk_dst & busy_q[sb.dec_dst]) | (trk_dst & full);

  always_comb begin
    issue    = 1'b0;
    sb.stall = 1'b1;
    sb.flush = 1'b0;
    if (reset) begin
      unique case (state_q)
        StRun: begin
          issue    = sb.dec_valid & ~hz;
          sb.stall = sb.dec_valid & hz;
        end
        StCtrlWait: sb.stall = 1'b1;
        StFlush: begin
          sb.stall = 1'b0;
          sb.flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sb.issue = issue;
  assign sb.busy  = busy_q;
  assign sb.state = state_q;
  assign sb.err   = err_q;

  assign inc    = issue & trk_dst;
  assign dec    = wb_trk & (inflight_q != '0);
  assign wb_err = wb_trk & (inflight_q == '0);

  always_comb begin
    busy_d = busy_q;
    if (dec) busy_d[sb.wb_reg] = 1'b0;
    // Set after clear so a same-edge issue to the retiring register stays busy.
    if (inc) busy_d[sb.dec_dst] = 1'b1;

    inflight_d = inflight_q;
    unique case ({inc, dec})
      2'b10:   inflight_d = inflight_q + CntW'(1);
      2'b01:   inflight_d = inflight_q - CntW'(1);
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    err_d       = err_q | wb_err | (sb.redirect & ~sb.resolve);
    unique case (state_q)
      StRun: begin
        if (sb.resolve) err_d = 1'b1;
        if (issue & sb.dec_ctrl) state_d = StCtrlWait;
      end
      StCtrlWait: begin
        if (sb.resolve & sb.redirect) begin
          flush_cnt_d = 2'(FLUSHCYCLES);
          state_d     = StFlush;
        end else if (sb.resolve) begin
          state_d = StRun;
        end
      end
      StFlush: begin
        if (sb.resolve) err_d = 1'b1;
        flush_cnt_d = flush_cnt_q - 2'd1;
        if (flush_cnt_q <= 2'd1) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StRun;
      busy_q      <= '0;
      inflight_q  <= '0;
      flush_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      inflight_q  <= inflight_d;
      flush_cnt_q <= flush_cnt_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: stimulus pushes hand-computed per-cycle expectations,
// a monitor pops and compares them half a cycle later.
module tb_issue_scoreboard;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  issue_scoreboard_if #(.REGNOBITS(5), .NUMREGS(32)) sb_if ();

  issue_scoreboard #(
    .REGNOBITS  (5),
    .NUMREGS    (32),
    .MAXINFLIGHT(2),
    .FLUSHCYCLES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sb   (sb_if)
  );

  typedef struct packed {
    int          id;
    logic        iss;
    logic        stl;
    logic        fl;
    logic [1:0]  st;
    logic        er;
    logic [31:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_id = 0;

  // Monitor: one expectation per stimulus cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (sb_if.issue !== e.iss || sb_if.stall !== e.stl || sb_if.flush !== e.fl ||
            sb_if.state !== e.st || sb_if.err !== e.er || sb_if.busy !== e.busy) begin
          errors++;
          $display("FAIL cyc%0d got iss=%b stl=%b fl=%b st=%0d err=%b busy=%h want iss=%b stl=%b fl=%b st=%0d err=%b busy=%h",
                   e.id, sb_if.issue, sb_if.stall, sb_if.flush, sb_if.state, sb_if.err,
                   sb_if.busy, e.iss, e.stl, e.fl, e.st, e.er, e.busy);
        end
      end
    end
  end

  task automatic cyc(input logic rst, input logic v, input logic [4:0] s1, input logic [4:0] s2,
                     input logic u2, input logic [4:0] d, input logic wb, input logic ct,
                     input logic wv, input logic [4:0] wr, input logic rs, input logic rd,
                     input logic iss, input logic stl, input logic fl, input logic [1:0] st,
                     input logic er, input logic [31:0] b);
    exp_t e;
    @(posedge clk);
    #1;
    reset               = rst;
    sb_if.dec_valid     = v;
    sb_if.dec_src1      = s1;
    sb_if.dec_src2      = s2;
    sb_if.dec_uses_src2 = u2;
    sb_if.dec_dst       = d;
    sb_if.dec_wb        = wb;
    sb_if.dec_ctrl      = ct;
    sb_if.wb_valid      = wv;
    sb_if.wb_reg        = wr;
    sb_if.resolve       = rs;
    sb_if.redirect      = rd;
    cyc_id++;
    e.id = cyc_id; e.iss = iss; e.stl = stl; e.fl = fl; e.st = st; e.er = er; e.busy = b;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset               = 1'b0;
    sb_if.dec_valid     = 1'b0;
    sb_if.dec_src1      = '0;
    sb_if.dec_src2      = '0;
    sb_if.dec_uses_src2 = 1'b0;
    sb_if.dec_dst       = '0;
    sb_if.dec_wb        = 1'b0;
    sb_if.dec_ctrl      = 1'b0;
    sb_if.wb_valid      = 1'b0;
    sb_if.wb_reg        = '0;
    sb_if.resolve       = 1'b0;
    sb_if.redirect      = 1'b0;

    //  rst v  s1 s2 u2 d  wb ct wv wr rs rd | iss stl fl st er busy
    // Reset forces stall; release issues the first writer, r5 becomes busy.
    cyc(0, 1, 3, 4, 1, 5, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 32'h0);
    cyc(1, 1, 3, 4, 1, 5, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 32'h0);
    // RAW on r5: stalls through the writeback cycle, issues the cycle after.
    cyc(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 32'h20);
    cyc(1, 1, 5, 0, 0, 0, 0, 0, 1, 5, 0, 0,  0, 1, 0, 0, 0, 32'h20);
    cyc(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 32'h0);
    // Branch not taken.
    cyc(1, 1, 1, 2, 1, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 32'h0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 32'h0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 1, 0, 32'h0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 32'h0);
    // Branch taken: two flush cycles, then run.
    cyc(1, 1, 1, 2, 1, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 32'h0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 1, 0, 1, 0, 32'h0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 2, 0, 32'h0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 2, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 32'h0);
    // Inflight limit: r1, r2 outstanding, r7 waits for one writeback.
    cyc(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 32'h0);
    cyc(1, 1, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 32'h2);
    cyc(1, 1, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 32'h6);
    cyc(1, 1, 0, 0, 0, 7, 1, 0, 1, 1, 0, 0,  0, 1, 0, 0, 0, 32'h6);
    cyc(1, 1, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 32'h4);
    // Same-edge set/clear of r6: r6 stays busy, count unchanged so r3 issues but r9 stalls.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0,  0, 0, 0, 0, 0, 32'h84);
    cyc(1, 1, 0, 0, 0, 6, 1, 0, 1, 6, 0, 0,  1, 0, 0, 0, 0, 32'h80);
    cyc(1, 1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 32'hC0);
    cyc(1, 1, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 32'hC8);
    // Drain to zero, then a spurious writeback sets the sticky error.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0,  0, 0, 0, 0, 0, 32'hC8);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0,  0, 0, 0, 0, 0, 32'h48);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0,  0, 0, 0, 0, 0, 32'h40);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 32'h40);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 32'h40);
    // JAL to r10, then reset while waiting on it.
    cyc(1, 1, 0, 0, 0, 10, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h40);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 1, 32'h440);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 1, 32'h440);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 32'h0);
    // Resolve while running is a protocol error.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 32'h0);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue/hazard controller for the 3-stage pipelined core (fetch/decode, execute, memory/writeback).
- Replaces ad-hoc register-number compare stalls with a per-register busy-bit scoreboard, a control-transfer sequencer, and an in-flight writeback counter.
- Sits beside decode. Drives PC stall, execute-buffer bubble insertion and post-redirect squash.

Parameters:
- REGNOBITS, 5, register number width.
- NUMREGS, 32, registers tracked.
- MAXINFLIGHT, 2, maximum outstanding writeback instructions.
- FLUSHCYCLES, 1, squash cycles after a redirect (legal range 1..3).

Ports:
- CLK  in  1  core clock.
- RESET  in  1  synchronous, active-low reset.
- DEC_VALID  in  1  decode holds a real (non-noop) instruction.
- DEC_SRC1  in  REGNOBITS  first source register (ry).
- DEC_SRC2  in  REGNOBITS  second source register (rz or rx).
- DEC_USES_SRC2  in  1  DEC_SRC2 is read.
- DEC_DST  in  REGNOBITS  destination register (rx).
- DEC_WB  in  1  instruction writes DEC_DST (ALUR/ALUI/LW/JAL).
- DEC_CTRL  in  1  instruction is a branch or JAL.
- WB_VALID  in  1  writeback stage writes the register file this cycle.
- WB_REG  in  REGNOBITS  register being written.
- RESOLVE  in  1  memory stage holds a resolved branch/JAL.
- REDIRECT  in  1  the resolved control transfer is taken; PC loads target at this edge.
- ISSUE  out  1  decode instruction advances into execute this edge.
- STALL  out  1  hold PC and load a bubble into the execute buffer.
- FLUSH  out  1  squash the fetched instruction (bubble, PC advances).
- BUSY  out  NUMREGS  busy-bit vector.
- STATE  out  2  FSM state: 0 RUN, 1 CTRL_WAIT, 2 FLUSH.
- ERR  out  1  sticky protocol error.

Behaviour:
Reset (RESET=0 sampled at posedge):
- BUSY=0, STATE=RUN, inflight counter=0, flush counter=0, ERR=0.
- While RESET=0, outputs are forced combinationally to ISSUE=0, STALL=1, FLUSH=0.
- Reset mid-operation discards all pending state with no completion.

Hazard (combinational, uses registered BUSY only):
- hz = BUSY[SRC1] | (USES_SRC2 & BUSY[SRC2]) | (DEC_WB & BUSY[DST]) | (DEC_WB & inflight==MAXINFLIGHT).
- There is no same-cycle bypass. A register cleared by WB this cycle still stalls this cycle and issues next cycle, because the register file writes at the edge.

RUN state:
- ISSUE = DEC_VALID & ~hz.
- STALL = DEC_VALID & hz.
- FLUSH = 0.
- If ISSUE & DEC_CTRL: next state CTRL_WAIT.

CTRL_WAIT state:
- ISSUE=0, STALL=1, FLUSH=0.
- On RESOLVE & REDIRECT: load flush counter with FLUSHCYCLES and go to FLUSH.
- On RESOLVE & ~REDIRECT: go to RUN; the held instruction is eligible next cycle.

FLUSH state:
- ISSUE=0, STALL=0, FLUSH=1.
- Counter decrements each cycle; at 1, go to RUN.

Busy/inflight updates at posedge:
- ISSUE & DEC_WB sets BUSY[DST] and increments inflight.
- WB_VALID clears BUSY[WB_REG] and decrements inflight.
- Simultaneous set and clear of the same register: set wins, BUSY stays 1.
- Simultaneous increment and decrement: inflight is unchanged.
- WB_VALID while inflight==0: ignored, ERR set.
- RESOLVE in RUN or FLUSH: ignored, ERR set.
- REDIRECT without RESOLVE: ignored, ERR set.
- ERR clears only on reset.

Latency: issue decision is zero-cycle (combinational). Busy state is visible one cycle after the issue edge.

Optional Feature:
- Macro: SCOREBOARD_R0_ZERO_EN.
- Defined: register 0 is never marked busy. Sources or destinations equal to 0 never cause hz. JAL to r0 does not increment inflight.
- Undefined: register 0 is tracked like any other register.

Test Plan:
- Reset release, DEC_VALID=1, SRC1=3, SRC2=4, DEC_WB=1, DST=5 -> ISSUE=1 that cycle; next cycle BUSY=0x00000020.
- RAW: issue a write to r5, next instruction reads r5 -> STALL=1 until WB_VALID,WB_REG=5 edge; ISSUE=1 the cycle after, not the same cycle.
- Issue a BEQ -> STATE=1, STALL=1; RESOLVE=1, REDIRECT=0 -> RUN next cycle, no FLUSH. Repeat with REDIRECT=1, FLUSHCYCLES=2 -> FLUSH=1 for exactly 2 cycles, then RUN.
- MAXINFLIGHT=2: two writes to r1 and r2 outstanding, third writer to r7 -> STALL=1; one WB_VALID -> third issues the following cycle.
- Same-edge ISSUE with DST=6 and WB_VALID with WB_REG=6 -> BUSY[6]=1 after the edge; inflight unchanged. WB_VALID with inflight 0 -> ERR=1, held until reset.
- RESET low asserted while in CTRL_WAIT with BUSY nonzero -> next cycle STATE=0, BUSY=0, ERR=0, ISSUE=0, STALL=1 while RESET stays low.
